// File: rtl/node_ram_arbiter_pkg.sv
// node_ram_arbiter_pkg: shared types and sizing for the node RAM arbiters.
package node_ram_arbiter_pkg;
  localparam int NODE_RAM_AW = 17;
  localparam int NODE_RAM_SEL = 23;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WACK  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RACK  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/node_ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with combinational grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/node_ram_arbiter.sv
// node_ram_arbiter: shares one node RAM port between the NIC and CPU Wishbone masters.
module node_ram_arbiter
  import node_ram_arbiter_pkg::*;
#(
  parameter int RD_LAT  = 3,
  parameter int AW      = NODE_RAM_AW,
  parameter int SEL_BIT = NODE_RAM_SEL
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [23:0]   m0_adr_i,
  input  logic [7:0]    m0_dat_i,
  output logic          m0_ack_o,
  output logic [7:0]    m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [23:0]   m1_adr_i,
  input  logic [7:0]    m1_dat_i,
  output logic          m1_ack_o,
  output logic [7:0]    m1_dat_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_adr_o,
  output logic [7:0]    ram_dat_o,
  input  logic [7:0]    ram_dat_i,
  output logic [1:0]    gnt_o
);
  arb_state_t state;
  logic [2:0] cnt;
  logic       sel, ack, abort, cyc, drop, we_g;
  logic [7:0] rd;
  logic [1:0] req, gnt;
  logic       unused;
  assign req = (state == ST_IDLE) ?
    {m1_cyc_i & m1_stb_i & ~m1_adr_i[SEL_BIT], m0_cyc_i & m0_stb_i & m0_adr_i[SEL_BIT]} : 2'b00;
  assign we_g = gnt[1] ? m1_we_i : m0_we_i;
  assign cyc = sel ? m1_cyc_i : m0_cyc_i;
  assign drop = abort | ~cyc;
  assign m0_ack_o = ack & ~sel;
  assign m1_ack_o = ack & sel;
  assign m0_dat_o = m0_ack_o ? rd : 8'h00;
  assign m1_dat_o = m1_ack_o ? rd : 8'h00;
  assign ram_en_o = rst_ni;
  assign unused = ^{m0_adr_i[23:AW], m1_adr_i[23:AW]};
  rr_arb2 u_arb (.clk(clk_i), .rst_n(rst_ni), .req(req), .gnt(gnt));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      ack       <= 1'b0;
      abort     <= 1'b0;
      rd        <= 8'h00;
      gnt_o     <= 2'b00;
      ram_we_o  <= 1'b0;
      ram_adr_o <= '0;
      ram_dat_o <= 8'h00;
    end else begin
      ram_we_o <= 1'b0;
      case (state)
        ST_IDLE: if (|gnt) begin
          sel       <= gnt[1];
          gnt_o     <= gnt;
          ram_adr_o <= gnt[1] ? m1_adr_i[AW-1:0] : m0_adr_i[AW-1:0];
          ram_dat_o <= gnt[1] ? m1_dat_i : m0_dat_i;
          ram_we_o  <= we_g;
          state     <= we_g ? ST_WACK : ST_RWAIT;
          cnt       <= 3'(RD_LAT - 1);
          abort     <= 1'b0;
        end
        ST_WACK: if (!cyc) begin
          ack   <= 1'b0;
          gnt_o <= 2'b00;
          state <= ST_IDLE;
        end else ack <= 1'b1;
        // A master that gave up mid-read still waits out the RAM latency, unacked.
        ST_RWAIT: if (cnt == 3'd0) begin
          state <= drop ? ST_IDLE : ST_RACK;
          ack   <= ~drop;
          rd    <= drop ? 8'h00 : ram_dat_i;
          if (drop) gnt_o <= 2'b00;
        end else begin
          cnt   <= cnt - 3'd1;
          abort <= drop;
        end
        ST_RACK: if (!cyc) begin
          ack   <= 1'b0;
          rd    <= 8'h00;
          gnt_o <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/node_ram_arbiter.md
Name: node_ram_arbiter

Overview:
- Arbitrates one port of a processing node's dual-port node RAM between two Wishbone-classic 8-bit masters.
- Requester 0 is the NIC bus-master port; requester 1 is the local rf6809 CPU.
- Sequences RAM enable, write strobe and a fixed-latency read, returns ack and data, and releases on cyc drop.
- One instance per RAM port; two per pnode.

Parameters:
- RD_LAT, 3: RAM read latency in clocks from address-valid edge to dout-valid; legal range 1..7.
- AW, 17: RAM address width.
- SEL_BIT, 23: address bit used for window decode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_cyc_i  in  1  NIC master cycle
- m0_stb_i  in  1  NIC master strobe
- m0_we_i  in  1  NIC master write enable
- m0_adr_i  in  24  NIC master address
- m0_dat_i  in  8  NIC master write data
- m0_ack_o  out  1  ack to NIC master
- m0_dat_o  out  8  read data to NIC master
- m1_cyc_i  in  1  CPU cycle
- m1_stb_i  in  1  CPU strobe
- m1_we_i  in  1  CPU write enable
- m1_adr_i  in  24  CPU address
- m1_dat_i  in  8  CPU write data
- m1_ack_o  out  1  ack to CPU
- m1_dat_o  out  8  read data to CPU
- ram_en_o  out  1  RAM port enable
- ram_we_o  out  1  RAM write strobe
- ram_adr_o  out  AW  RAM address
- ram_dat_o  out  8  RAM write data
- ram_dat_i  in  8  RAM read data
- gnt_o  out  2  one-hot current grant, for debug and performance counters

Behaviour:
- Reset (async assert, sync deassert) sets:
  - state = ST_IDLE
  - all acks = 0
  - m0_dat_o and m1_dat_o = 8'h00
  - ram_we_o = 0, ram_en_o = 0, ram_adr_o = 0, ram_dat_o = 0
  - gnt_o = 0
  - last-granted pointer = 1, so the NIC wins the first tie
- Window decode:
  - m0 requests RAM only when m0_cyc_i & m0_stb_i & m0_adr_i[SEL_BIT] = 1.
  - m1 requests RAM only when m1_cyc_i & m1_stb_i & m1_adr_i[SEL_BIT] = 0.
  - Out-of-window cycles are ignored and never acked here; the NIC slave or other decoders handle them.
- ram_en_o is 1 whenever not in reset.
- Data outputs are zero whenever the corresponding ack is 0, so they can be OR-combined with other slave data.
- Arbitration in ST_IDLE:
  - Single requester: it is granted.
  - Both requesting: round-robin, granting the one not granted last.
  - On grant: latch adr[AW-1:0], we and write data into ram_adr_o / ram_dat_o; set gnt_o; update the last-granted pointer.
- ST_IDLE transitions:
  - Write grant: ram_we_o = 1 for exactly one clock (the grant edge), then go to ST_WACK.
  - Read grant: go to ST_RWAIT with the latency counter = RD_LAT-1.
- ST_WACK: assert the granted ack; hold it until the granted cyc_i falls, then clear the ack and return to ST_IDLE.
- ST_RWAIT: decrement the counter each clock; at 0, capture ram_dat_i into the granted dat_o, set the ack, and go to ST_RACK.
- ST_RACK: hold ack and data stable until the granted cyc_i falls, then clear both (dat_o to 00) in the same edge and go to ST_IDLE.
- Latency:
  - Write ack rises 2 clocks after the request is sampled.
  - Read ack rises RD_LAT+1 clocks after the request is sampled.
- Master abandons the cycle (cyc_i drops) in ST_RWAIT: finish the counter, suppress the ack, return to ST_IDLE; no data is driven.
- Back-to-back: at least one ST_IDLE clock between grants; the other requester, if waiting, is granted on that clock.
- m_we_i, m_adr_i and m_dat_i changing after the grant are ignored; the latched values are used.
- Illegal state encodings go to ST_IDLE.

Decomposition:
- nic_pkg gains:
  - state enum arb_state_t {ST_IDLE, ST_WACK, ST_RWAIT, ST_RACK}
  - localparam NODE_RAM_AW = 17
  - localparam NODE_RAM_SEL = 23
- Sub-module rr_arb2 (2-input round-robin, combinational grant, registered last-grant pointer) is natural and reusable for the NIC IPacket path.
- pnode instantiates two node_ram_arbiter instances in place of its inline per-port sequencers.

Test Plan:
- CPU write: m1 writes adr 000123 = A5 with RD_LAT = 3. ram_we_o pulses once with ram_adr_o = 00123 and ram_dat_o = A5; m1_ack_o rises 2 clocks later and falls 1 clock after cyc drops.
- NIC read: m0 reads adr 800123, with the RAM model returning A5 at 00123. m0_ack_o rises at 4 clocks with m0_dat_o = A5; m0_dat_o is 00 the clock after cyc drops.
- Simultaneous requests: m0 reads 800010 and m1 writes 000020 in the same clock after reset. The NIC is granted first; the CPU is granted on the first ST_IDLE clock after the NIC releases. With both held continuously, gnt_o alternates 01, 10, 01.
- Out of window: m1 uses adr 800000 and m0 uses adr 000000. No ack, no ram_we_o, and gnt_o stays 0 for 20 clocks.
- Abort: m1 read, with cyc dropped during ST_RWAIT. m1_ack_o is never asserted, m1_dat_o stays 00, and the arbiter is back in ST_IDLE after RD_LAT clocks.
- Reset mid-read: rst_ni asserted low during ST_RACK. Acks, data and ram_we_o go to 0 asynchronously, before the next clock edge; the first request after release is granted to the NIC on a tie.
